// File: rtl/game_controller.sv
// game_controller: round sequencer for the calculator game.
// Drives the state code and seed into the question generator, times the
// player's answer, checks it against the generator's result and keeps
// score, lives, streak and level until the lives run out.
module game_controller #(
  parameter int unsigned     TIME_LIMIT     = 100,
  parameter int unsigned     START_LIVES    = 3,
  parameter int unsigned     LEVEL_UP_COUNT = 4,
  parameter int unsigned     MAX_LEVEL      = 3,
  parameter logic [27:0]     SEED_INIT      = 28'h5A5A5A5
) (
  input  logic        tick,
  input  logic        reset_n,
  input  logic        start,
  input  logic        enter,
  input  logic [9:0]  answer,
  input  logic        gen_done,
  input  logic [9:0]  result,
  output logic [3:0]  state,
  output logic [2:0]  level,
  output logic [27:0] seed_out,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic [7:0]  time_left,
  output logic        correct,
  output logic        wrong,
  output logic        game_over
);

  // Encoding is fixed: the generator decodes GEN (2) directly.
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ARM   = 4'd1,
    S_GEN   = 4'd2,
    S_ASK   = 4'd3,
    S_CHECK = 4'd4,
    S_RIGHT = 4'd5,
    S_WRONG = 4'd6,
    S_OVER  = 4'd7
  } state_t;

  localparam logic [7:0] TL      = 8'(TIME_LIMIT);
  localparam logic [1:0] LIVES0  = 2'(START_LIVES);
  localparam logic [7:0] LVL_CNT = 8'(LEVEL_UP_COUNT);
  localparam logic [2:0] LVL_MAX = 3'(MAX_LEVEL);

  state_t      state_q, state_d;
  logic [27:0] lfsr_q, seed_q;
  logic        gen_first_q;
  logic [9:0]  expected_q, answer_q;
  logic [7:0]  time_left_q, score_q, streak_q;
  logic [1:0]  lives_q;
  logic [2:0]  level_q;
  logic        enter_gen;
  logic        streak_hit;

  // A fresh GEN dwell starts on any transition into GEN from another state.
  assign enter_gen  = (state_d == S_GEN) && (state_q != S_GEN);
  assign streak_hit = (streak_q + 8'd1) == LVL_CNT;

  // State register.
  always_ff @(posedge tick or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ARM;
      S_ARM:   state_d = S_GEN;
      // gen_done is ignored on the first GEN tick so the generator always
      // sees at least two ticks of state==2, even if its flag is stale.
      S_GEN:   if (gen_done && !gen_first_q) state_d = S_ASK;
      S_ASK: begin
        if (enter)                   state_d = S_CHECK;
        else if (time_left_q == 8'd1) state_d = S_WRONG;
      end
      S_CHECK: state_d = (answer_q == expected_q) ? S_RIGHT : S_WRONG;
      S_RIGHT: state_d = S_GEN;
      S_WRONG: state_d = (lives_q <= 2'd1) ? S_OVER : S_GEN;
      S_OVER:  if (start) state_d = S_ARM;
      default: state_d = S_IDLE;
    endcase
  end

  // Free-running LFSR (taps 28,25); seed captured only on entry to GEN so it
  // stays frozen for the whole generator dwell.
  always_ff @(posedge tick or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED_INIT;
      seed_q <= SEED_INIT;
    end else begin
      lfsr_q <= {lfsr_q[26:0], lfsr_q[27] ^ lfsr_q[24]};
      if (enter_gen) seed_q <= lfsr_q;
    end
  end

  // Question handshake: latch the expected result, run the answer timer,
  // capture the player's answer.
  always_ff @(posedge tick or negedge reset_n) begin
    if (!reset_n) begin
      gen_first_q <= 1'b0;
      expected_q  <= '0;
      answer_q    <= '0;
      time_left_q <= '0;
    end else begin
      gen_first_q <= enter_gen;
      if (state_q == S_GEN && state_d == S_ASK) begin
        expected_q  <= result;
        time_left_q <= TL;
      end else if (state_q == S_ASK) begin
        if (enter)                    answer_q    <= answer;
        else if (time_left_q == 8'd1) time_left_q <= 8'd0;
        else                          time_left_q <= time_left_q - 8'd1;
      end
    end
  end

  // Game bookkeeping: score, lives, streak and level.
  always_ff @(posedge tick or negedge reset_n) begin
    if (!reset_n) begin
      score_q  <= '0;
      lives_q  <= LIVES0;
      level_q  <= 3'd1;
      streak_q <= '0;
    end else begin
      case (state_q)
        S_ARM: begin
          score_q  <= '0;
          lives_q  <= LIVES0;
          level_q  <= 3'd1;
          streak_q <= '0;
        end
        S_RIGHT: begin
          if (score_q != 8'hFF) score_q <= score_q + 8'd1;
          if (streak_hit) begin
            streak_q <= '0;
            if (level_q < LVL_MAX) level_q <= level_q + 3'd1;
          end else begin
            streak_q <= streak_q + 8'd1;
          end
        end
        S_WRONG: begin
          streak_q <= '0;
          lives_q  <= lives_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Pulses are state decodes, so correct/wrong are mutually exclusive and
  // exactly one tick wide.
  assign state     = state_q;
  assign level     = level_q;
  assign seed_out  = seed_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign time_left = time_left_q;
  assign correct   = (state_q == S_RIGHT);
  assign wrong     = (state_q == S_WRONG);
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a simple generator model.
module tb_game_controller;

  localparam logic [27:0] SEED = 28'h5A5A5A5;

  logic        tick = 1'b0, reset_n = 1'b0, start = 1'b0, enter = 1'b0;
  logic [9:0]  answer = '0, result = 10'd42;
  logic        gen_done = 1'b0;
  logic [3:0]  state;
  logic [2:0]  level;
  logic [27:0] seed_out;
  logic [7:0]  score, time_left;
  logic [1:0]  lives;
  logic        correct, wrong, game_over;

  int checks = 0, errors = 0;
  logic [27:0] m_lfsr, snap;
  int lvl_tab [12] = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3};

  game_controller dut (
    .tick(tick), .reset_n(reset_n), .start(start), .enter(enter),
    .answer(answer), .gen_done(gen_done), .result(result),
    .state(state), .level(level), .seed_out(seed_out), .score(score),
    .lives(lives), .time_left(time_left), .correct(correct),
    .wrong(wrong), .game_over(game_over)
  );

  always #5 tick = ~tick;

  // Generator model: raises done while it sees state==2 (already high on the
  // first GEN edge, which exercises the minimum-dwell guard).
  always @(negedge tick) gen_done = (state == 4'd2);

  // Reference LFSR, taps 28,25.
  always @(posedge tick or negedge reset_n) begin
    if (!reset_n) m_lfsr <= SEED;
    else          m_lfsr <= {m_lfsr[26:0], m_lfsr[27] ^ m_lfsr[24]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge tick);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd1);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_lives"}, 32'(lives), 32'd3);
    chk({tag, "_tleft"}, 32'(time_left), 32'd0);
    chk({tag, "_pulses"}, {29'd0, correct, wrong, game_over}, 32'd0);
    chk({tag, "_seed"}, 32'(seed_out), 32'(SEED));
  endtask

  // From the first GEN tick through to the first ASK tick.
  task automatic ask_from_gen();
    logic [27:0] s;
    chk("gen1_state", 32'(state), 32'd2);
    s = seed_out;
    cyc();
    chk("gen2_state", 32'(state), 32'd2);
    chk("gen_seed_stable", 32'(seed_out), 32'(s));
    cyc();
    chk("ask_state", 32'(state), 32'd3);
    chk("ask_tleft", 32'(time_left), 32'd100);
  endtask

  // Submit an answer from ASK and follow CHECK -> RIGHT/WRONG -> nxt.
  task automatic do_ans(input logic [9:0] a, input bit right, input logic [3:0] nxt);
    enter = 1'b1; answer = a;
    cyc();
    enter = 1'b0;
    chk("check_state", 32'(state), 32'd4);
    cyc();
    chk("verdict_state", 32'(state), right ? 32'd5 : 32'd6);
    chk("verdict_pulses", {30'd0, correct, wrong}, right ? 32'd2 : 32'd1);
    snap = m_lfsr;
    cyc();
    chk("after_state", 32'(state), 32'(nxt));
    chk("after_pulses", {30'd0, correct, wrong}, 32'd0);
    if (nxt == 4'd2) chk("reload_seed", 32'(seed_out), 32'(snap));
  endtask

  initial begin
    // Reset values.
    #11;
    chk_reset("rst");
    reset_n = 1'b1;
    #1;
    // Test 1: 0,1,2,3,4,5,2 with result=42, answer=42.
    start = 1'b1;
    cyc();
    chk("arm_state", 32'(state), 32'd1);
    start = 1'b0;
    snap = m_lfsr;
    cyc();
    chk("arm_seed", 32'(seed_out), 32'(snap));
    ask_from_gen();
    do_ans(10'd42, 1'b1, 4'd2);
    chk("t1_score", 32'(score), 32'd1);

    // Test 5: enter on the tick where time_left==1 wins over timeout.
    ask_from_gen();
    repeat (99) cyc();
    chk("t5_state", 32'(state), 32'd3);
    chk("t5_tleft", 32'(time_left), 32'd1);
    do_ans(10'd42, 1'b1, 4'd2);
    chk("t5_score", 32'(score), 32'd2);

    // Test 2: timeout after exactly 100 ASK ticks.
    result = 10'd7;
    ask_from_gen();
    for (int i = 1; i < 100; i++) begin
      cyc();
      chk("t2_ask_hold", 32'(state), 32'd3);
    end
    chk("t2_tleft1", 32'(time_left), 32'd1);
    cyc();
    chk("t2_wrong_state", 32'(state), 32'd6);
    chk("t2_pulses", {30'd0, correct, wrong}, 32'd1);
    chk("t2_tleft0", 32'(time_left), 32'd0);
    cyc();
    chk("t2_gen_state", 32'(state), 32'd2);
    chk("t2_lives", 32'(lives), 32'd2);

    // Test 3: level rises every 4 correct answers, saturates at 3.
    for (int k = 0; k < 12; k++) begin
      ask_from_gen();
      do_ans(10'd7, 1'b1, 4'd2);
      chk("t3_level", 32'(level), 32'(lvl_tab[k]));
    end
    chk("t3_score", 32'(score), 32'd14);

    // Test 4: wrong answers (bit 9 only differs) end the game.
    ask_from_gen();
    do_ans(10'd7 | 10'h200, 1'b0, 4'd2);
    chk("t4_lives1", 32'(lives), 32'd1);
    ask_from_gen();
    do_ans(10'd8, 1'b0, 4'd7);
    chk("t4_over", {29'd0, game_over, lives}, 32'h4);
    enter = 1'b1;
    cyc();
    enter = 1'b0;
    chk("t4_enter_ignored", 32'(state), 32'd7);
    start = 1'b1;
    cyc();
    chk("t4_rearm", 32'(state), 32'd1);
    start = 1'b0;
    cyc();
    chk("t4_restart", {16'd0, score, 3'd0, level, 2'd0, lives}, {16'd0, 8'd0, 3'd0, 3'd1, 2'd0, 2'd3});

    // Streak cleared by a wrong answer: 2 right, 1 wrong, 3 right -> still level 1.
    for (int k = 0; k < 2; k++) begin ask_from_gen(); do_ans(10'd7, 1'b1, 4'd2); end
    ask_from_gen();
    do_ans(10'd9, 1'b0, 4'd2);
    for (int k = 0; k < 3; k++) begin ask_from_gen(); do_ans(10'd7, 1'b1, 4'd2); end
    chk("streak_cleared_level", 32'(level), 32'd1);
    ask_from_gen();
    do_ans(10'd7, 1'b1, 4'd2);
    chk("streak_levelup", 32'(level), 32'd2);
    chk("streak_score", 32'(score), 32'd6);

    // Test 6: asynchronous reset mid-ASK.
    ask_from_gen();
    repeat (5) cyc();
    #2 reset_n = 1'b0;
    #1;
    chk_reset("async");
    #10 reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound so the bench always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout checks=%0d", checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
